one_bit_processor: RTL and testbench
====================================

Name: one_bit_processor

Overview:
- Single-bit accumulator processor ("Stupid Machine") with a 16-entry, 13-bit instruction memory.
- While `en`=1 the memory is loaded serially from `inReg[0]`. While `en`=0 the stored program executes at one instruction per clock.
- Programs read 2 external input bits and drive 7 output register bits. Used as a tiny programmable controller, e.g. a shift register or a pause/branch loop.

Parameters:
- INSTR_WIDTH, 13, instruction word width (fixed by encoding).
- MEM_DEPTH, 16, instruction memory depth; PC and jump targets are 4 bits.
- OUT_REGS, 7, number of output register bits.
- IN_REGS, 2, number of input bits.
- INT_REGS, 6, number of internal scratch bits R0–R5.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  1 = serial program load mode; 0 = execute mode.
- inReg  input  2  external inputs IN0/IN1; IN0 is also the serial load data. Sampled directly at clk edges; no internal synchronizer.
- outReg  output  7  registered output bits OUT0–OUT6.

Behaviour:
- Reset (reset=0, asynchronous) clears all state to 0:
  - PC, ACC, outReg, internal R0–R5;
  - all 16 instruction words;
  - load bit counter, load slot pointer, load shift buffer.
- The all-zero memory decodes as NOP, so a freshly reset device idles with outReg=0.
- Load mode (en=1), on each rising edge:
  - shift `inReg[0]` into the word, MSB first;
  - on the 13th bit, write {buffer[11:0], inReg[0]} to instructions[load_ptr] on that same edge, increment load_ptr (wraps 15→0), and clear the bit counter.
  - Consecutive 13-bit words fill consecutive slots.
  - During load: PC is held at 0; ACC, outReg and internal regs hold their values.
- Whenever en=0:
  - bit counter, buffer and load_ptr are cleared; a partial word is discarded;
  - each new en assertion loads starting at slot 0.
- Execute mode (en=0): on each rising edge execute instructions[PC].
  - Register and ACC updates take effect at that edge.
  - PC becomes PC+1 (wraps 15→0) or the jump target.
  - The first instruction executes on the first edge with en=0.
- Encoding: [12:9] opcode, [8:5] operand address A, [4] reserved (ignored), [3:0] jump target T.
- Address map:
  - 0–6 = OUT0–OUT6 (read/write);
  - 7–8 = IN0–IN1 (read-only; writes ignored);
  - 9–14 = R0–R5 (read/write);
  - 15 = constant 0 (writes ignored).
- Opcodes:
  - 0 NOP.
  - 1 LD: ACC=A.
  - 2 LDN: ACC=~A.
  - 3 AND: ACC&=A.
  - 4 OR: ACC|=A.
  - 5 XOR: ACC^=A.
  - 6 ST: A=ACC.
  - 7 STN: A=~ACC.
  - 8 JMP: PC=T.
  - 9 JZ: PC=T if ACC==0, else PC+1.
  - 10 JNZ: PC=T if ACC==1, else PC+1.
  - 11 SET: A=1.
  - 12 CLR: A=0.
  - 13–15: NOP (reserved).
- ST/SET/CLR/STN to OUTn change outReg[n] at that edge; outReg reflects state with zero combinational delay.
- Switching en 0→1 mid-program: PC resets to 0 on the next edge; register state is retained.
- Reset mid-load or mid-execution: everything clears immediately, including already loaded instructions.

Test Plan:
- Reset pulse → PC=0, outReg=7'b0, internal regs=0, all 16 instruction words=0; with en=0, outReg stays 0 for 32 cycles.
- en=1, IN0=1 for 13 cycles → instructions[0]=13'h1FFF. Then IN0=0 for 13 cycles → instructions[1]=0 and instructions[0] unchanged. Alternating bits 1,0,1… → instructions[2]=13'b1010101010101.
- Load LD IN0 (13'b0001011100000), ST OUT0 (13'b0110000000000), JMP 0 (13'b1000000000000), then en=0 → outReg[0] tracks IN0 within 3 cycles; outReg[6:1] stay 0.
- Pause/branch program: LD IN1; JNZ 0; SET OUT3; JMP 0.
  - IN1=1 → outReg stays 0 indefinitely (e.g. 40 cycles).
  - IN1=0 → outReg[3]=1 within 4 cycles.
- Shift register program: OUTk+1=OUTk for k=5..0, OUT0=IN0, guarded by an IN1 pause check. Feed IN0 sequence 1,0,1,1 with one program pass per bit → outReg=7'b0001011. IN1=1 holds that value.
- Drop en mid-word after 5 bits, then reassert en and load 13 bits → the word lands in slot 0. Reset asserted during execution → outReg=0 immediately (asynchronously).

Source files
------------

// File: rtl/one_bit_processor.sv
// rtl/one_bit_processor.sv - single-bit accumulator processor with a serially loaded program memory
//
// Purpose:
//   A 16-word x 13-bit program memory is filled serially from inReg[0] while en=1,
//   MSB first, one bit per clock. While en=0 the stored program runs at one
//   instruction per clock against a 1-bit accumulator.
//
//   Instruction word: [12:9] opcode, [8:5] operand address, [4] reserved, [3:0] jump target.
//   Operand space:    0-6 OUT0-OUT6, 7-8 IN0-IN1 (read-only), 9-14 R0-R5, 15 constant 0.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset, clears every state bit including the program
//   en     - 1 = serial program load, 0 = execute
//   inReg  - external inputs IN0/IN1; IN0 doubles as the serial load data
//   outReg - registered output bits OUT0-OUT6

module one_bit_processor #(
    parameter int INSTR_WIDTH = 13,
    parameter int MEM_DEPTH   = 16,
    parameter int OUT_REGS    = 7,
    parameter int IN_REGS     = 2,
    parameter int INT_REGS    = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [IN_REGS-1:0]  inReg,
    output logic [OUT_REGS-1:0] outReg
);

    localparam int PC_W    = $clog2(MEM_DEPTH);
    localparam int SPACE_W = OUT_REGS + IN_REGS + INT_REGS + 1;

    localparam logic [3:0] OUT_LAST = 4'(OUT_REGS - 1);
    localparam logic [3:0] INT_BASE = 4'(OUT_REGS + IN_REGS);
    localparam logic [3:0] INT_LAST = 4'(OUT_REGS + IN_REGS + INT_REGS - 1);
    localparam logic [3:0] LAST_BIT = 4'(INSTR_WIDTH - 1);

    localparam logic [3:0] OP_LD  = 4'd1;
    localparam logic [3:0] OP_LDN = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_ST  = 4'd6;
    localparam logic [3:0] OP_STN = 4'd7;
    localparam logic [3:0] OP_JMP = 4'd8;
    localparam logic [3:0] OP_JZ  = 4'd9;
    localparam logic [3:0] OP_JNZ = 4'd10;
    localparam logic [3:0] OP_SET = 4'd11;
    localparam logic [3:0] OP_CLR = 4'd12;

    logic [INSTR_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [PC_W-1:0]        r_pc;
    logic                   r_acc;
    logic [OUT_REGS-1:0]    r_out;
    logic [INT_REGS-1:0]    r_int;
    logic [3:0]             r_bit_cnt;
    logic [PC_W-1:0]        r_load_ptr;
    logic [INSTR_WIDTH-2:0] r_buf;

    logic [INSTR_WIDTH-1:0] w_instr;
    logic [3:0]             w_opcode;
    logic [3:0]             w_addr;
    logic [PC_W-1:0]        w_target;
    logic                   w_unused_rsvd;
    logic [SPACE_W-1:0]     w_space;
    logic                   w_operand;
    logic [2:0]             w_int_idx;

    logic                   w_acc_next;
    logic [PC_W-1:0]        w_pc_next;
    logic                   w_wr_en;
    logic                   w_wr_val;
    logic [OUT_REGS-1:0]    w_out_next;
    logic [INT_REGS-1:0]    w_int_next;

    assign w_instr       = r_mem[r_pc];
    assign w_opcode      = w_instr[12:9];
    assign w_addr        = w_instr[8:5];
    assign w_unused_rsvd = w_instr[4];
    assign w_target      = w_instr[3:0];

    // Flat view of the operand space; bit position equals operand address, top bit is the constant 0.
    assign w_space   = {1'b0, r_int, inReg, r_out};
    assign w_operand = w_space[w_addr];
    assign w_int_idx = 3'(w_addr - INT_BASE);

    always_comb begin
        w_acc_next = r_acc;
        w_pc_next  = r_pc + 1'b1;
        w_wr_en    = 1'b0;
        w_wr_val   = 1'b0;
        w_out_next = r_out;
        w_int_next = r_int;

        case (w_opcode)
            OP_LD:  w_acc_next = w_operand;
            OP_LDN: w_acc_next = ~w_operand;
            OP_AND: w_acc_next = r_acc & w_operand;
            OP_OR:  w_acc_next = r_acc | w_operand;
            OP_XOR: w_acc_next = r_acc ^ w_operand;
            OP_ST:  begin w_wr_en = 1'b1; w_wr_val = r_acc;  end
            OP_STN: begin w_wr_en = 1'b1; w_wr_val = ~r_acc; end
            OP_JMP: w_pc_next = w_target;
            OP_JZ:  if (!r_acc) w_pc_next = w_target;
            OP_JNZ: if (r_acc)  w_pc_next = w_target;
            OP_SET: begin w_wr_en = 1'b1; w_wr_val = 1'b1; end
            OP_CLR: begin w_wr_en = 1'b1; w_wr_val = 1'b0; end
            default: ;
        endcase

        // Writes to the inputs or the constant-0 address fall through both ranges and are dropped.
        if (w_wr_en) begin
            if (w_addr <= OUT_LAST) begin
                w_out_next[w_addr[2:0]] = w_wr_val;
            end else if (w_addr >= INT_BASE && w_addr <= INT_LAST) begin
                w_int_next[w_int_idx] = w_wr_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pc       <= '0;
            r_acc      <= 1'b0;
            r_out      <= '0;
            r_int      <= '0;
            r_bit_cnt  <= '0;
            r_load_ptr <= '0;
            r_buf      <= '0;
        end else if (en) begin
            // Program counter parks at 0 so execution restarts from the top once en drops.
            r_pc <= '0;
            if (r_bit_cnt == LAST_BIT) begin
                r_mem[r_load_ptr] <= {r_buf, inReg[0]};
                r_load_ptr        <= r_load_ptr + 1'b1;
                r_bit_cnt         <= '0;
                r_buf             <= '0;
            end else begin
                r_buf     <= {r_buf[INSTR_WIDTH-3:0], inReg[0]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end else begin
            // Leaving load mode discards any partial word; the next load begins at slot 0.
            r_bit_cnt  <= '0;
            r_load_ptr <= '0;
            r_buf      <= '0;
            r_pc       <= w_pc_next;
            r_acc      <= w_acc_next;
            r_out      <= w_out_next;
            r_int      <= w_int_next;
        end
    end

    assign outReg = r_out;

endmodule

// File: tb/tb_one_bit_processor.sv
// tb/tb_one_bit_processor.sv - self-checking bench for one_bit_processor

module tb_one_bit_processor;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] inReg;
    logic [6:0] outReg;

    always #5 clk = ~clk;

    one_bit_processor dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .inReg  (inReg),
        .outReg (outReg)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] exp_q  [$];
    string      name_q [$];

    typedef struct {
        logic       en;
        logic [1:0] in;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [$];

    localparam logic [3:0] A_OUT0 = 4'd0;
    localparam logic [3:0] A_IN0  = 4'd7;
    localparam logic [3:0] A_IN1  = 4'd8;

    function automatic logic [12:0] enc(input logic [3:0] op, input logic [3:0] a, input logic [3:0] t);
        return {op, a, 1'b0, t};
    endfunction

    task automatic check_val(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, queue the expectation, compare at the next falling edge.
    task automatic step(input logic e, input logic [1:0] in, input logic [6:0] exp, input string name);
        en    = e;
        inReg = in;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk);
        @(negedge clk);
        check_val(name_q.pop_front(), {6'b0, outReg}, {6'b0, exp_q.pop_front()});
    endtask

    task automatic tick(input logic e, input logic [1:0] in);
        en    = e;
        inReg = in;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vecs(input string name);
        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].in, vecs[i].exp, $sformatf("%s[%0d]", name, i));
        end
        vecs.delete();
    endtask

    task automatic load_word(input logic [12:0] w);
        for (int i = 12; i >= 0; i--) begin
            tick(1'b1, {inReg[1], w[i]});
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        en    = 1'b0;
        inReg = 2'b00;
        @(negedge clk);
        check_val("reset_out", {6'b0, outReg}, 13'h0);
        reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

    logic [12:0] prog_a [3];
    logic [12:0] prog_p [4];
    logic [12:0] prog_s [16];
    logic [3:0]  shift_bits;
    logic [6:0]  sr_model;

    initial begin
        prog_a[0] = 13'b0001011100000;
        prog_a[1] = 13'b0110000000000;
        prog_a[2] = 13'b1000000000000;

        prog_p[0] = enc(4'd1,  A_IN1, 4'd0);
        prog_p[1] = enc(4'd10, 4'd15, 4'd0);
        prog_p[2] = enc(4'd11, 4'd3,  4'd0);
        prog_p[3] = enc(4'd8,  4'd15, 4'd0);

        prog_s[0] = enc(4'd1,  A_IN1, 4'd0);
        prog_s[1] = enc(4'd10, 4'd15, 4'd0);
        for (int k = 0; k < 6; k++) begin
            prog_s[2 + 2*k] = enc(4'd1, 4'(5 - k), 4'd0);
            prog_s[3 + 2*k] = enc(4'd6, 4'(6 - k), 4'd0);
        end
        prog_s[14] = enc(4'd1, A_IN0, 4'd0);
        prog_s[15] = enc(4'd6, A_OUT0, 4'd0);

        // Reset state
        reset = 1'b0;
        en    = 1'b0;
        inReg = 2'b00;
        repeat (2) @(negedge clk);
        check_val("reset_out", {6'b0, outReg}, 13'h0);
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("reset_mem[%0d]", i), dut.r_mem[i], 13'h0);
        end
        reset = 1'b1;

        // Cleared memory idles as NOP
        for (int i = 0; i < 32; i++) begin
            vecs.push_back('{en: 1'b0, in: 2'($urandom_range(0, 3)), exp: 7'h00});
        end
        run_vecs("idle");

        // Serial load into consecutive slots
        inReg = 2'b00;
        load_word(13'h1FFF);
        check_val("load_slot0_ones", dut.r_mem[0], 13'h1FFF);
        load_word(13'h0000);
        check_val("load_slot1_zeros", dut.r_mem[1], 13'h0000);
        check_val("load_slot0_kept", dut.r_mem[0], 13'h1FFF);
        load_word(13'b1010101010101);
        check_val("load_slot2_alt", dut.r_mem[2], 13'b1010101010101);
        step(1'b0, 2'b00, 7'h00, "gap_nop");

        // Pass-through program: OUT0 follows IN0 with a three-instruction loop
        for (int i = 0; i < 3; i++) load_word(prog_a[i]);
        vecs.push_back('{en: 1'b0, in: 2'b11, exp: 7'h00});
        vecs.push_back('{en: 1'b0, in: 2'b10, exp: 7'h01});
        vecs.push_back('{en: 1'b0, in: 2'b10, exp: 7'h01});
        vecs.push_back('{en: 1'b0, in: 2'b10, exp: 7'h01});
        vecs.push_back('{en: 1'b0, in: 2'b11, exp: 7'h00});
        vecs.push_back('{en: 1'b0, in: 2'b11, exp: 7'h00});
        vecs.push_back('{en: 1'b0, in: 2'b11, exp: 7'h00});
        vecs.push_back('{en: 1'b0, in: 2'b11, exp: 7'h01});
        vecs.push_back('{en: 1'b0, in: 2'b10, exp: 7'h01});
        run_vecs("passthru");

        // Pause/branch program
        do_reset();
        inReg = 2'b10;
        for (int i = 0; i < 4; i++) load_word(prog_p[i]);
        for (int i = 0; i < 40; i++) begin
            vecs.push_back('{en: 1'b0, in: {1'b1, 1'($urandom_range(0, 1))}, exp: 7'h00});
        end
        vecs.push_back('{en: 1'b0, in: 2'b00, exp: 7'h00});
        vecs.push_back('{en: 1'b0, in: 2'b00, exp: 7'h00});
        vecs.push_back('{en: 1'b0, in: 2'b00, exp: 7'h08});
        vecs.push_back('{en: 1'b0, in: 2'b01, exp: 7'h08});
        vecs.push_back('{en: 1'b0, in: 2'b10, exp: 7'h08});
        run_vecs("pause");

        // Shift register program, one 16-instruction pass per input bit
        do_reset();
        inReg = 2'b10;
        for (int i = 0; i < 16; i++) load_word(prog_s[i]);
        shift_bits = 4'b1011;
        sr_model   = 7'h00;
        for (int b = 3; b >= 0; b--) begin
            sr_model = {sr_model[5:0], shift_bits[b]};
            for (int c = 0; c < 15; c++) tick(1'b0, {1'b0, shift_bits[b]});
            step(1'b0, {1'b0, shift_bits[b]}, sr_model, $sformatf("shift_pass%0d", 3 - b));
        end
        for (int i = 0; i < 20; i++) begin
            vecs.push_back('{en: 1'b0, in: {1'b1, 1'($urandom_range(0, 1))}, exp: 7'b0001011});
        end
        run_vecs("shift_hold");

        // Partial word dropped by en=0; the next full word lands in slot 0
        for (int i = 0; i < 5; i++) tick(1'b1, 2'b11);
        step(1'b0, 2'b10, 7'b0001011, "drop_gap");
        inReg = 2'b10;
        load_word(enc(4'd11, 4'd6, 4'd0));
        for (int i = 0; i < 6; i++) begin
            vecs.push_back('{en: 1'b0, in: 2'b10, exp: 7'b1001011});
        end
        run_vecs("relaod_slot0");

        // Asynchronous reset during execution
        #2;
        reset = 1'b0;
        #1;
        check_val("async_reset_out", {6'b0, outReg}, 13'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vecs.push_back('{en: 1'b0, in: 2'($urandom_range(0, 3)), exp: 7'h00});
        end
        run_vecs("post_reset_idle");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
